fir_sample_sink: RTL and testbench

//   Output end of the FIR sample path: captures filtered samples from fir_filter /
//   fir_filter_sep at the sample rate and buffers them in a show-ahead FIFO.

---
 rtl/fir_sample_sink.sv | 146 ++++++++++++++
 tb/tb_fir_sample_sink.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_sink.sv
// Sample sink for the FIR output path: strobe-aligned capture into a show-ahead
// FIFO drained over a valid/ready handshake, with a sticky overflow flag.
module fir_sample_sink #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CAP_DELAY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_stb,
    input  logic [DATA_W-1:0]        in_data,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PINC_C  = {{(PW-1){1'b0}}, 1'b1};

    logic              cap_s;
    logic              pop_s;
    logic              wr_en_s;
    logic              drop_s;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    // Strobe delay line: one bit per clock of delay, so closely spaced strobes each survive.
    generate
        if (CAP_DELAY == 0) begin : g_nodly
            assign cap_s = in_stb;
        end else if (CAP_DELAY == 1) begin : g_dly1
            logic dly_q;
            // Single-stage strobe delay.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dly_q <= 1'b0;
                end else begin
                    dly_q <= in_stb;
                end
            end
            assign cap_s = dly_q;
        end else begin : g_dlyn
            logic [CAP_DELAY-1:0] dly_q;
            // Multi-stage strobe delay.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dly_q <= {CAP_DELAY{1'b0}};
                end else begin
                    dly_q <= {dly_q[CAP_DELAY-2:0], in_stb};
                end
            end
            assign cap_s = dly_q[CAP_DELAY-1];
        end
    endgenerate

    // Next-state logic for pointers, occupancy, overflow and the registered head.
    always_comb begin
        pop_s       = out_valid_q & out_ready;
        // A pop on a full FIFO frees the slot on the same edge.
        wr_en_s     = cap_s & ((count_q != FULL_C) | pop_s);
        drop_s      = cap_s & ~wr_en_s;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PINC_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PINC_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        out_valid_d = (count_d != ZERO_C);
        // Head slot being written this edge must show the incoming sample next cycle.
        if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            out_data_d = in_data;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= ZERO_C;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_sample_sink.sv
// Directed bench for fir_sample_sink (DATA_W=8, DEPTH=16, CAP_DELAY=1).
module tb_fir_sample_sink;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_stb;
    logic [7:0] in_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf;

    int n_cmp = 0;
    int n_mis = 0;

    fir_sample_sink #(.DATA_W(8), .DEPTH(16), .CAP_DELAY(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_stb    (in_stb),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stb;
        logic [7:0] data;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_data;
        logic [4:0] e_count;
        logic       e_ovf;
    } vec_t;

    vec_t       tbl [22];
    logic [7:0] fs [17];
    logic [7:0] mq [$];
    int         pops;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_sample(input logic [7:0] s);
        in_stb = 1'b1; in_data = s; tick();
        in_stb = 1'b0; tick();
    endtask

    // One cycle of the wrap test with an order-only scoreboard.
    task automatic cyc(input logic stb, input logic [7:0] d, input logic rdy);
        logic [7:0] e;
        in_stb = stb; in_data = d; out_ready = rdy;
        if (out_valid && rdy) begin
            e = (mq.size() != 0) ? mq.pop_front() : 8'hxx;
            chk("wrap_order", out_data, e);
            pops++;
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_stb = 1'b0; in_data = 8'h00; out_ready = 1'b0; clr_ovf = 1'b0;

        tbl[0]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[1]  = '{1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h7F, 5'd1, 1'b0};
        tbl[2]  = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 8'h7F, 5'd1, 1'b0};
        tbl[3]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[4]  = '{1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 5'd1, 1'b0};
        tbl[5]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h80, 5'd1, 1'b0};
        tbl[6]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h80, 5'd2, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 5'd1, 1'b0};
        tbl[8]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0};
        tbl[10] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[11] = '{1'b0, 8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 5'd1, 1'b0};
        tbl[12] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[13] = '{1'b0, 8'h90, 1'b0, 1'b0, 1'b1, 8'h90, 5'd1, 1'b0};
        tbl[14] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 8'h90, 5'd1, 1'b0};
        tbl[15] = '{1'b0, 8'h91, 1'b1, 1'b0, 1'b1, 8'h91, 5'd1, 1'b0};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[17] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[18] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA1, 5'd1, 1'b0};
        tbl[19] = '{1'b0, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 5'd2, 1'b0};
        tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA2, 5'd1, 1'b0};
        tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};

        // Reset held 3 clocks with strobes pulsing, then one cycle after release.
        for (int i = 0; i < 3; i++) begin
            in_stb = (i != 1); in_data = 8'(8'h40 + i);
            tick();
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_count", count, 5'd0);
            chk("rst_ovf", overflow, 1'b0);
        end
        chk("rst_data", out_data, 8'h00);
        rst_n = 1'b1; in_stb = 1'b0;
        tick();
        chk("rel_valid", out_valid, 1'b0);
        chk("rel_count", count, 5'd0);
        chk("rel_ovf", overflow, 1'b0);

        // Table-driven vectors: alignment, handshake, simultaneous pop+capture.
        for (int i = 0; i < 22; i++) begin
            in_stb = tbl[i].stb; in_data = tbl[i].data;
            out_ready = tbl[i].rdy; clr_ovf = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].e_count);
            chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].e_ovf);
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
        end
        in_stb = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;

        // Stream: one strobe per 20 clocks, consumer always ready.
        begin
            logic [7:0] ss [4];
            int maxc;
            ss[0] = 8'h80; ss[1] = 8'hFF; ss[2] = 8'h00; ss[3] = 8'h7F;
            maxc = 0;
            out_ready = 1'b1;
            for (int s = 0; s < 4; s++) begin
                int nv;
                nv = 0;
                for (int c = 0; c < 20; c++) begin
                    in_stb = (c == 0); in_data = ss[s];
                    tick();
                    if (int'(count) > maxc) maxc = int'(count);
                    if (out_valid) begin
                        nv++;
                        chk("stream_data", out_data, ss[s]);
                    end
                end
                chk("stream_valid_cycles", nv, 1);
            end
            chk("stream_max_count", maxc, 1);
            out_ready = 1'b0;
        end

        // Fill past full, drain, then clear overflow.
        for (int i = 0; i < 17; i++) begin
            fs[i] = 8'(i * 13 + 7);
            push_sample(fs[i]);
        end
        chk("fill_count", count, 5'd16);
        chk("fill_ovf", overflow, 1'b1);
        chk("fill_head", out_data, fs[0]);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_data", out_data, fs[i]);
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty_valid", out_valid, 1'b0);
        chk("drain_empty_count", count, 5'd0);
        chk("drain_ovf_sticky", overflow, 1'b1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 1'b0);

        // Full FIFO with pop and capture on the same edge.
        for (int i = 0; i < 16; i++) begin
            fs[i] = 8'(8'hC0 + i);
            push_sample(fs[i]);
        end
        chk("full_count", count, 5'd16);
        in_stb = 1'b1; in_data = 8'h3C; tick();
        in_stb = 1'b0; out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        chk("fullsim_count", count, 5'd16);
        chk("fullsim_ovf", overflow, 1'b0);
        chk("fullsim_head", out_data, fs[1]);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("fullsim_drain", out_data, (i < 15) ? fs[i + 1] : 8'h3C);
            tick();
        end
        out_ready = 1'b0;
        chk("fullsim_empty", out_valid, 1'b0);

        // Forty samples through the FIFO, wrapping both pointers.
        pops = 0;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] s;
            s = 8'(i * 37 + 5);
            mq.push_back(s);
            cyc(1'b1, s, (i >= 10));
            cyc(1'b0, s, (i >= 10) && (i % 2 == 1));
        end
        for (int k = 0; k < 40 && mq.size() > 0; k++) cyc(1'b0, 8'h00, 1'b1);
        out_ready = 1'b0;
        chk("wrap_pops", pops, 40);
        chk("wrap_count", count, 5'd0);
        chk("wrap_valid", out_valid, 1'b0);

        // Mid-run reset with a strobe in flight.
        for (int i = 0; i < 5; i++) push_sample(8'(8'h20 + i));
        chk("mid_count5", count, 5'd5);
        rst_n = 1'b0; in_stb = 1'b1; in_data = 8'hAA; tick();
        chk("mid_rst_count", count, 5'd0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 8'h00);
        rst_n = 1'b1; in_stb = 1'b0; tick();
        chk("mid_rel_count", count, 5'd0);
        chk("mid_rel_valid", out_valid, 1'b0);
        push_sample(8'h5A);
        chk("post_rst_count", count, 5'd1);
        chk("post_rst_data", out_data, 8'h5A);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("post_rst_pop", count, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
